// File: rtl/pc_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl_pkg
//  Purpose  : Shared core defines for the fetch-PC redirect controller:
//             FSM state codes and the instruction width constant.
//  Revision : 1.0  initial release
// ============================================================================
package pc_redirect_ctrl_pkg;

    // Fetch-control FSM state encoding, shared with the core.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_t;

    // Width of one instruction in bytes: the sequential PC increment.
    localparam logic [31:0] c_instr_bytes = 32'd4;

    // A redirect target is legal only when it is word aligned.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : pc_redirect_ctrl_pkg
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl
//  Purpose  : Fetch PC generator. Advances the PC on accepted fetches,
//             redirects to jump/branch targets with a fixed-length flush
//             window, and halts permanently on a misaligned target.
//  Revision : 1.0  initial release
// ============================================================================
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2              // legal range 1..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        jb_enable,
    input  logic [31:0] jb_target_pc,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign_err,
    output logic [31:0] misalign_addr,
    output logic [15:0] redirect_count
);

    // The flush counter counts down to zero, so FLUSH spans FLUSH_CYCLES cycles.
    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    pc_state_t   state_q,          state_d;
    logic [2:0]  flush_cnt_q,      flush_cnt_d;
    logic [31:0] pc_q,             pc_d;
    logic        fetch_valid_q,    fetch_valid_d;
    logic        flush_q,          flush_d;
    logic        misalign_err_q,   misalign_err_d;
    logic [31:0] misalign_addr_q,  misalign_addr_d;
    logic [15:0] redirect_count_q, redirect_count_d;

    // Next-state logic: redirect beats sequential increment; FLUSH and HALT
    // ignore jb_enable because it belongs to an instruction being killed.
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        pc_d             = pc_q;
        misalign_err_d   = misalign_err_q;
        misalign_addr_d  = misalign_addr_q;
        redirect_count_d = redirect_count_q;

        unique case (state_q)
            ST_RUN: begin
                if (jb_enable) begin
                    if (is_word_aligned(jb_target_pc)) begin
                        pc_d             = jb_target_pc;
                        redirect_count_d = redirect_count_q + 16'd1;
                        flush_cnt_d      = c_flush_load;
                        state_d          = ST_FLUSH;
                    end else begin
                        misalign_err_d   = 1'b1;
                        misalign_addr_d  = jb_target_pc;
                        state_d          = ST_HALT;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_q + c_instr_bytes;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        fetch_valid_d = (state_d == ST_RUN);
        flush_d       = (state_d != ST_RUN);
    end

    // State and output registers; reset overrides everything, even HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            flush_cnt_q      <= 3'd0;
            pc_q             <= RESET_PC;
            fetch_valid_q    <= 1'b1;
            flush_q          <= 1'b0;
            misalign_err_q   <= 1'b0;
            misalign_addr_q  <= 32'h0000_0000;
            redirect_count_q <= 16'h0000;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            pc_q             <= pc_d;
            fetch_valid_q    <= fetch_valid_d;
            flush_q          <= flush_d;
            misalign_err_q   <= misalign_err_d;
            misalign_addr_q  <= misalign_addr_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc             = pc_q;
    assign fetch_valid    = fetch_valid_q;
    assign flush          = flush_q;
    assign misalign_err   = misalign_err_q;
    assign misalign_addr  = misalign_addr_q;
    assign redirect_count = redirect_count_q;

endmodule : pc_redirect_ctrl
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_redirect_ctrl
//  Purpose  : Directed self-checking bench for pc_redirect_ctrl with
//             hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic        jb_enable;
    logic [31:0] jb_target_pc;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_err;
    logic [31:0] misalign_addr;
    logic [15:0] redirect_count;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_ready     (imem_ready),
        .jb_enable      (jb_enable),
        .jb_target_pc   (jb_target_pc),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .misalign_err   (misalign_err),
        .misalign_addr  (misalign_addr),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Snapshot of the visible fetch state.
    task automatic check_fetch(input string tag, input logic [31:0] e_pc,
                               input logic e_fv, input logic e_fl);
        check({tag, "_pc"},    pc,                  e_pc);
        check({tag, "_fv"},    {31'd0, fetch_valid}, {31'd0, e_fv});
        check({tag, "_flush"}, {31'd0, flush},       {31'd0, e_fl});
    endtask

    initial begin
        reset        = 1'b1;
        imem_ready   = 1'b0;
        jb_enable    = 1'b0;
        jb_target_pc = 32'h0;
        step();
        check_fetch("rst", 32'h0, 1'b1, 1'b0);
        check("rst_err",   {31'd0, misalign_err}, 32'd0);
        check("rst_addr",  misalign_addr,          32'd0);
        check("rst_count", {16'd0, redirect_count}, 32'd0);

        // Sequential fetch
        reset = 1'b0; imem_ready = 1'b1;
        step(); check_fetch("seq1", 32'h4, 1'b1, 1'b0);
        step(); check_fetch("seq2", 32'h8, 1'b1, 1'b0);

        // Stall holds pc
        imem_ready = 1'b0;
        step(); check_fetch("stall1", 32'h8, 1'b1, 1'b0);
        step(); check_fetch("stall2", 32'h8, 1'b1, 1'b0);
        imem_ready = 1'b1;
        step(); check_fetch("seq3", 32'hC, 1'b1, 1'b0);

        // Redirect with imem_ready=1: redirect wins
        jb_enable = 1'b1; jb_target_pc = 32'h100;
        step(); check_fetch("redir", 32'h100, 1'b0, 1'b1);
        check("redir_count", {16'd0, redirect_count}, 32'd1);

        // jb_enable during FLUSH is ignored
        jb_target_pc = 32'h200;
        step(); check_fetch("flush2", 32'h100, 1'b0, 1'b1);
        check("flush2_count", {16'd0, redirect_count}, 32'd1);
        jb_enable = 1'b0;
        step(); check_fetch("tgt_fetch", 32'h100, 1'b1, 1'b0);
        step(); check_fetch("tgt_next", 32'h104, 1'b1, 1'b0);
        check("tgt_count", {16'd0, redirect_count}, 32'd1);

        // Misaligned target -> HALT
        jb_enable = 1'b1; jb_target_pc = 32'h102;
        step(); check_fetch("halt", 32'h104, 1'b0, 1'b1);
        check("halt_err",   {31'd0, misalign_err}, 32'd1);
        check("halt_addr",  misalign_addr,          32'h102);
        check("halt_count", {16'd0, redirect_count}, 32'd1);
        jb_target_pc = 32'h300;
        step(); check_fetch("halt_hold", 32'h104, 1'b0, 1'b1);
        check("halt_addr2", misalign_addr, 32'h102);
        check("halt_err2",  {31'd0, misalign_err}, 32'd1);

        // Reset leaves HALT
        jb_enable = 1'b0; reset = 1'b1;
        step(); check_fetch("halt_rst", 32'h0, 1'b1, 1'b0);
        check("halt_rst_err",   {31'd0, misalign_err}, 32'd0);
        check("halt_rst_addr",  misalign_addr,          32'd0);
        check("halt_rst_count", {16'd0, redirect_count}, 32'd0);
        reset = 1'b0;

        // Redirect with imem_ready=0 to the top word, then wrap
        imem_ready = 1'b0; jb_enable = 1'b1; jb_target_pc = 32'hFFFF_FFFC;
        step(); check_fetch("wrap_redir", 32'hFFFF_FFFC, 1'b0, 1'b1);
        check("wrap_count", {16'd0, redirect_count}, 32'd1);
        jb_enable = 1'b0; imem_ready = 1'b1;
        step(); check_fetch("wrap_fl2", 32'hFFFF_FFFC, 1'b0, 1'b1);
        step(); check_fetch("wrap_run", 32'hFFFF_FFFC, 1'b1, 1'b0);
        step(); check_fetch("wrap_zero", 32'h0, 1'b1, 1'b0);

        // Reset mid-FLUSH
        jb_enable = 1'b1; jb_target_pc = 32'h40;
        step(); check_fetch("mid_redir", 32'h40, 1'b0, 1'b1);
        check("mid_count", {16'd0, redirect_count}, 32'd2);
        jb_enable = 1'b0; reset = 1'b1;
        step(); check_fetch("mid_rst", 32'h0, 1'b1, 1'b0);
        check("mid_rst_count", {16'd0, redirect_count}, 32'd0);
        reset = 1'b0;
        step(); check_fetch("post_rst", 32'h4, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pc_redirect_ctrl
`default_nettype wire
